// File: rtl/ysyx_24110015_pkg.sv
// Shared definitions for the ysyx_24110015 fetch path: FSM encoding,
// AXI response codes and the default boot address.
package ysyx_24110015_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_24110015_ifu.sv
// Multi-cycle instruction fetch unit: owns the PC, issues one AXI4-Lite read
// per fetch and holds the returned instruction for decode.
module ysyx_24110015_ifu
  import ysyx_24110015_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            control_iMemRead,
  output logic            control_iMemRead_end,
  input  logic            pc_wen,
  input  logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            fetch_err,
  output logic [31:0]     fetch_cnt,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            err_q, err_d;
  logic [31:0]     cnt_q, cnt_d;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

  // The PC may only move while idle, so the address of an in-flight read
  // cannot change underneath the slave.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pc_wen) begin
          pc_d = align_pc(npc);
        end
        if (control_iMemRead) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rvalid) begin
          state_d = ST_DONE;
          inst_d  = rdata;
          err_d   = resp_is_err(rresp);
          cnt_d   = cnt_q + 32'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are pure state decodes; nothing combinational from inputs.
  assign arvalid              = (state_q == ST_ADDR);
  assign rready               = (state_q == ST_DATA);
  assign control_iMemRead_end = (state_q == ST_DONE);
  assign araddr               = pc_q;
  assign pc                   = pc_q;
  assign inst                 = inst_q;
  assign fetch_err            = err_q;
  assign fetch_cnt            = cnt_q;

endmodule

// File: tb/tb_ysyx_24110015_ifu.sv
// Self-checking bench for ysyx_24110015_ifu: a cycle-counting memory and
// controller model predict every handshake, the end pulse and the fetch results.
module tb_ysyx_24110015_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        control_iMemRead;
  logic        ctl_end;
  logic        pc_wen;
  logic [31:0] npc;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        fetch_err;
  logic [31:0] fetch_cnt;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  ysyx_24110015_ifu dut (
    .clk                  (clk),
    .rst                  (rst),
    .control_iMemRead     (control_iMemRead),
    .control_iMemRead_end (ctl_end),
    .pc_wen               (pc_wen),
    .npc                  (npc),
    .pc                   (pc),
    .inst                 (inst),
    .fetch_err            (fetch_err),
    .fetch_cnt            (fetch_cnt),
    .araddr               (araddr),
    .arvalid              (arvalid),
    .arready              (arready),
    .rdata                (rdata),
    .rresp                (rresp),
    .rvalid               (rvalid),
    .rready               (rready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc   = RST_PC;
  logic [31:0] m_inst = 32'h0;
  logic        m_err  = 1'b0;
  logic [31:0] m_cnt  = 32'h0;
  int          exp_ends = 0;

  int cyc      = 0;
  int last_end = -100;
  int end_seen = 0;
  int gap_bad  = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ctl_end) begin
      end_seen <= end_seen + 1;
      if (cyc - last_end < 3) gap_bad <= gap_bad + 1;
      last_end <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle; returns in the IDLE cycle following DONE.
  task automatic fetch(input logic [31:0] data, input logic [1:0] resp,
                       input int ard, input int rd, input bit early, input bit drop,
                       input bit wen0, input logic [31:0] wen_npc, input bit wen_mid);
    int rv_from;
    int done_k;
    rv_from = early ? 1 : 2 + ard + rd;
    done_k  = early ? 3 + ard : 3 + ard + rd;
    control_iMemRead = 1'b1;
    rdata   = data;
    rresp   = resp;
    arready = 1'b0;
    rvalid  = 1'b0;
    if (wen0) begin
      pc_wen = 1'b1;
      npc    = wen_npc;
      m_pc   = wen_npc & ~32'h3;
    end
    for (int k = 1; k <= done_k; k++) begin
      tick();
      pc_wen = 1'b0;
      if (drop) control_iMemRead = 1'b0;
      chk("pc", pc, m_pc);
      chk("arvalid", {31'b0, arvalid}, {31'b0, k <= 1 + ard});
      chk("rready", {31'b0, rready}, {31'b0, (k >= 2 + ard) && (k < done_k)});
      chk("end", {31'b0, ctl_end}, {31'b0, k == done_k});
      if (k <= 1 + ard) chk("araddr", araddr, m_pc);
      arready = (k >= 1 + ard);
      rvalid  = (k >= rv_from);
      if (wen_mid && k == 2 + ard) begin
        pc_wen = 1'b1;
        npc    = $urandom;
      end
    end
    m_inst = data;
    m_err  = (resp != 2'b00);
    m_cnt  = m_cnt + 32'd1;
    exp_ends++;
    chk("inst", inst, m_inst);
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    chk("fetch_cnt", fetch_cnt, m_cnt);
    control_iMemRead = 1'b0;
    arready = 1'b0;
    rvalid  = 1'b0;
    tick();
    chk("end_width", {31'b0, ctl_end}, 32'h0);
    chk("idle_arvalid", {31'b0, arvalid}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    control_iMemRead = 1'b0;
    pc_wen  = 1'b0;
    npc     = 32'h0;
    arready = 1'b0;
    rdata   = 32'h0;
    rresp   = 2'b00;
    rvalid  = 1'b0;
    tick();
    tick();
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    chk("rst_arvalid", {31'b0, arvalid}, 32'h0);
    chk("rst_rready", {31'b0, rready}, 32'h0);
    chk("rst_end", {31'b0, ctl_end}, 32'h0);
    rst = 1'b0;
    tick();

    // Single zero-wait fetch
    fetch(32'h0010_0093, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t1_inst", inst, 32'h0010_0093);
    chk("t1_cnt", fetch_cnt, 32'd1);

    // Stalled handshakes
    fetch($urandom, 2'b00, 4, 3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // PC load in IDLE, then a fetch with pc_wen pulsed during DATA
    pc_wen = 1'b1;
    npc    = 32'h8000_0013;
    tick();
    pc_wen = 1'b0;
    m_pc   = 32'h8000_0010;
    chk("pc_load", pc, 32'h8000_0010);
    fetch($urandom, 2'b00, 1, 2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("pc_hold", pc, 32'h8000_0010);

    // PC load together with the request
    fetch($urandom, 2'b00, 0, 1, 1'b0, 1'b0, 1'b1, 32'h8000_1237, 1'b0);

    // Error response, then recovery
    fetch(32'hDEAD_BEEF, 2'b10, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("err_set", {31'b0, fetch_err}, 32'h1);
    chk("err_inst", inst, 32'hDEAD_BEEF);
    fetch($urandom, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("err_clr", {31'b0, fetch_err}, 32'h0);

    // Early rvalid and request dropped mid-flight
    fetch($urandom, 2'b00, 2, 0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch($urandom, 2'b00, 2, 2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Reset in DATA with rvalid low
    pc_wen = 1'b1;
    npc    = 32'h8000_4444;
    tick();
    pc_wen = 1'b0;
    control_iMemRead = 1'b1;
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("mid_rready", {31'b0, rready}, 32'h1);
    rst = 1'b1;
    tick();
    m_pc = RST_PC; m_inst = 32'h0; m_err = 1'b0; m_cnt = 32'h0;
    chk("mid_arvalid", {31'b0, arvalid}, 32'h0);
    chk("mid_rready0", {31'b0, rready}, 32'h0);
    chk("mid_pc", pc, RST_PC);
    chk("mid_cnt", fetch_cnt, 32'h0);
    chk("mid_end", {31'b0, ctl_end}, 32'h0);
    rst = 1'b0;
    control_iMemRead = 1'b0;
    tick();
    chk("mid_end2", {31'b0, ctl_end}, 32'h0);
    chk("mid_idle", {31'b0, arvalid | rready}, 32'h0);

    // 100 randomized back-to-back fetches
    for (int i = 0; i < 100; i++) begin
      logic [1:0] rsp;
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fetch($urandom, rsp, $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), $urandom, 1'($urandom_range(0, 1)));
    end
    chk("b2b_cnt", fetch_cnt, 32'd100);
    tick();
    chk("end_count", end_seen, exp_ends);
    chk("end_gap", gap_bad, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
